mult_serial_seq: RTL and testbench
==================================

Name: mult_serial_seq

Overview:
- Sequencer that drives the bit-serial multiplier `mult_mnbit_ncc` and returns the full product as a word.
- Upstream side: accepts a parallel operand pair (G, E) over a valid/ready handshake.
- Multiplier side: holds E on `e_init`, pulses the multiplier reset, then streams G LSB-first followed by zero padding on `g_input`.
- Captures the serial product stream `o` into an N+M-bit word and presents it downstream over a valid/ready handshake.

Parameters:
- N, 8, width of serial operand G.
- M, 8, width of parallel operand E (drives multiplier `e_init`).
- LAT, 2, cycles from `g_input` bit t driven to product bit t visible on `o`; must be ≥1.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_g  input  N  operand G.
- in_e  input  M  operand E.
- mult_rst  output  1  active-high reset to multiplier.
- g_input  output  1  serial G bit to multiplier.
- e_init  output  M  registered E to multiplier.
- o  input  1  serial product bit from multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  downstream accepts product.
- out_p  output  N+M  product G*E, unsigned.

Behaviour:
- Reset values (rst=0, asynchronous): state=IDLE, in_ready=1, mult_rst=1, g_input=0, e_init=0, out_valid=0, out_p=0, step counter t=0.
- All outputs are registered.
- IDLE:
  - in_ready=1, mult_rst=1.
  - On an edge with in_valid&in_ready: latch G into a shift register and E into e_init; go to PRIME.
- PRIME (exactly 1 cycle):
  - in_ready=0, mult_rst=1, g_input=0.
  - Next state SHIFT with t=0.
- SHIFT:
  - mult_rst=0.
  - During step t, g_input = G[t] for t<N, else 0.
  - At the end of step t, if t≥LAT, capture o into out_p[t-LAT].
  - t increments each cycle.
  - After the capture at t = N+M+LAT-1, go to DONE. SHIFT therefore lasts N+M+LAT cycles.
- DONE:
  - out_valid=1, out_p stable, mult_rst=1, g_input=0.
  - On an edge with out_valid&out_ready: out_valid→0, go to IDLE. in_ready is 1 the following cycle.
- Latency: out_valid rises N+M+LAT+1 cycles after the acceptance edge (default 19). There is no overlap; the next acceptance is earliest 1 cycle after the handshake.
- Unsigned arithmetic: out_p = in_g*in_e mod 2^(N+M), i.e. exact.
- Boundary conditions:
  - in_valid while busy is ignored: in_ready=0, operands not sampled.
  - out_ready held low: DONE held indefinitely, out_p stable.
  - out_ready high on entry to DONE: 1-cycle out_valid pulse.
  - in_g/in_e changing after acceptance has no effect.
  - rst asserted mid-SHIFT or mid-DONE aborts immediately to reset values. The partial product is discarded and no out_valid is emitted.
  - out_p bits not yet captured keep their previous value until overwritten; out_p is only defined while out_valid=1.

Optional Feature:
- Macro MULT_SERIAL_SEQ_CHECK_EN.
- Defined:
  - Adds output port chk_err (1 bit, reset 0).
  - The block computes the reference product in_g*in_e combinationally at acceptance and registers it.
  - In DONE, chk_err = (out_p != reference); it is cleared with out_valid.
- Not defined: port and logic absent; the core behaviour above is identical.

Test Plan:
- G=0xFF, E=0xAA, N=M=8, LAT=2, out_ready=1 → out_valid exactly 19 cycles after acceptance, out_p=0xA956, 1-cycle pulse; g_input sequence 1×8 then 0×10.
- G=0x80, E=0x80 then G=0x00, E=0xFF back-to-back, in_valid held high → out_p=0x4000 then 0x0000. Second acceptance occurs 1 cycle after the first output handshake; in_valid during busy is not sampled.
- G=0x03, E=0x05 with out_ready=0 for 10 cycles after out_valid → out_valid and out_p=0x000F held stable, then released on the first out_ready=1 edge.
- rst=0 for 1 cycle at SHIFT step 6 → all outputs at reset values immediately and no out_valid. A new pair G=0x0F, E=0x11 then yields out_p=0x00FF.
- Randomized 200 operand pairs with random out_ready → every out_p equals G*E; mult_rst is high in every non-SHIFT cycle; e_init is constant through SHIFT.
- With MULT_SERIAL_SEQ_CHECK_EN defined, force o to 0 during one SHIFT step for G=0xFF, E=0xAA → chk_err=1 with out_valid; an unforced run gives chk_err=0.

Source files
------------

// File: rtl/mult_serial_seq.sv
// Sequencer for the bit-serial multiplier: streams G, collects the product.
// Optional self-check port chk_err under MULT_SERIAL_SEQ_CHECK_EN.
module mult_serial_seq #(
  parameter int N   = 8,
  parameter int M   = 8,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_g,
  input  logic [M-1:0] in_e,
  output logic         mult_rst,
  output logic         g_input,
  output logic [M-1:0] e_init,
  input  logic         o,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N+M-1:0] out_p
`ifdef MULT_SERIAL_SEQ_CHECK_EN
  ,
  output logic         chk_err
`endif
);

  localparam int P    = N + M;
  localparam int LAST = N + M + LAT - 1;
  localparam int TW   = $clog2(N + M + LAT);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    SHIFT,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  t_q, t_d;
  logic [N-1:0]   g_sr_q, g_sr_d;
  logic [M-1:0]   e_q, e_d;
  logic           in_ready_q, in_ready_d;
  logic           mult_rst_q, mult_rst_d;
  logic           g_q, g_d;
  logic           out_valid_q, out_valid_d;
  logic [P-1:0]   out_p_q, out_p_d;
  logic           accept;
  logic           last;
  logic [TW-1:0]  cap_idx;

  assign accept  = (state_q == IDLE) && in_valid && in_ready_q;
  assign last    = (t_q == TW'(LAST));
  assign cap_idx = t_q - TW'(LAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      g_sr_q      <= '0;
      e_q         <= '0;
      in_ready_q  <= 1'b1;
      mult_rst_q  <= 1'b1;
      g_q         <= 1'b0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      g_sr_q      <= g_sr_d;
      e_q         <= e_d;
      in_ready_q  <= in_ready_d;
      mult_rst_q  <= mult_rst_d;
      g_q         <= g_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = PRIME;
      PRIME: begin
        state_d = SHIFT;
        t_d     = '0;
      end
      SHIFT: begin
        if (last) state_d = DONE;
        else      t_d     = t_q + TW'(1);
      end
      DONE:  if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    g_sr_d      = g_sr_q;
    e_d         = e_q;
    out_p_d     = out_p_q;
    in_ready_d  = (state_d == IDLE);
    mult_rst_d  = (state_d != SHIFT);
    out_valid_d = (state_d == DONE);
    g_d         = 1'b0;
    if (accept) begin
      g_sr_d = in_g;
      e_d    = in_e;
    end
    // g_input is registered, so the bit for the next step is picked now
    if (state_d == SHIFT) begin
      g_d    = g_sr_q[0];
      g_sr_d = g_sr_q >> 1;
    end
    if (state_q == SHIFT && t_q >= TW'(LAT)) begin
      for (int i = 0; i < P; i++) begin
        if (cap_idx == TW'(i)) out_p_d[i] = o;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign mult_rst  = mult_rst_q;
  assign g_input   = g_q;
  assign e_init    = e_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;

`ifdef MULT_SERIAL_SEQ_CHECK_EN
  logic [P-1:0] ref_q, ref_d;
  logic         chk_q, chk_d;

  always_comb begin
    ref_d = ref_q;
    chk_d = chk_q;
    if (accept) ref_d = P'(in_g) * P'(in_e);
    if (state_d != DONE)
      chk_d = 1'b0;
    else if (state_q == SHIFT)
      chk_d = (out_p_d != ref_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_q <= '0;
      chk_q <= 1'b0;
    end else begin
      ref_q <= ref_d;
      chk_q <= chk_d;
    end
  end

  assign chk_err = chk_q;
`endif

endmodule

// File: tb/tb_mult_serial_seq.sv
// Bench for mult_serial_seq: serial multiplier model plus timeline model.
// Build with MULT_SERIAL_SEQ_CHECK_EN to also exercise chk_err.
module tb_mult_serial_seq;

  localparam int N   = 8;
  localparam int M   = 8;
  localparam int LAT = 2;
  localparam int DK  = N + M + LAT + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_g;
  logic [7:0]  in_e;
  logic        mult_rst;
  logic        g_input;
  logic [7:0]  e_init;
  logic        o;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
`ifdef MULT_SERIAL_SEQ_CHECK_EN
  logic        chk_err;
`endif

  int checks = 0;
  int errors = 0;

  mult_serial_seq #(.N(N), .M(M), .LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_g(in_g),
    .in_e(in_e),
    .mult_rst(mult_rst),
    .g_input(g_input),
    .e_init(e_init),
    .o(o),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p(out_p)
`ifdef MULT_SERIAL_SEQ_CHECK_EN
    ,
    .chk_err(chk_err)
`endif
  );

  always #5 clk = ~clk;

  // Serial multiplier: product bit t appears on o LAT cycles after G bit t.
  int          mstep = 0;
  logic [31:0] gacc = '0;
  logic        pipe0 = 1'b0;
  logic        pipe1 = 1'b0;
  logic        o_force = 1'b0;

  function automatic logic pbit(input logic [31:0] ga,
                                input logic [7:0] e, input int s);
    logic [31:0] pr;
    pr = ga * {24'd0, e};
    return pr[s];
  endfunction

  always @(posedge clk) begin
    if (mult_rst) begin
      mstep <= 0;
      gacc  <= '0;
      pipe0 <= 1'b0;
    end else begin
      gacc  <= gacc | ({31'd0, g_input} << mstep);
      pipe0 <= pbit(gacc | ({31'd0, g_input} << mstep), e_init, mstep);
      mstep <= mstep + 1;
    end
    pipe1 <= pipe0;
  end

  assign o = o_force ? 1'b0 : pipe1;

  // Timeline model: k counts edges since acceptance.
  bit         busy = 1'b0;
  int         k = 0;
  logic [7:0] mg = '0;
  logic [7:0] me = '0;
  logic [15:0] p_mask = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      k    <= 0;
    end else if (busy) begin
      if (k >= DK && out_ready) busy <= 1'b0;
      else                      k    <= k + 1;
    end else if (in_valid) begin
      busy <= 1'b1;
      k    <= 0;
      mg   <= in_g;
      me   <= in_e;
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic sh, ev, eg;
    logic [15:0] ep;
    sh = busy && k >= 1 && k <= N + M + LAT;
    ev = busy && k >= DK;
    eg = 1'b0;
    if (sh && k - 1 < N) eg = mg[k-1];
    ep = ({8'd0, mg} * {8'd0, me}) ^ p_mask;
    check("in_ready", {31'd0, in_ready}, {31'd0, !busy});
    check("mult_rst", {31'd0, mult_rst}, {31'd0, !sh});
    check("g_input", {31'd0, g_input}, {31'd0, eg});
    check("out_valid", {31'd0, out_valid}, {31'd0, ev});
    if (busy) check("e_init", {24'd0, e_init}, {24'd0, me});
    if (ev) check("out_p", {16'd0, out_p}, {16'd0, ep});
`ifdef MULT_SERIAL_SEQ_CHECK_EN
    check("chk_err", {31'd0, chk_err}, {31'd0, ev && p_mask != 0});
`endif
  endtask

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (busy && k == 0) ok = 1'b1;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic send(input logic [7:0] g, input logic [7:0] e);
    bit ok;
    @(negedge clk);
    in_valid = 1'b1;
    in_g     = g;
    in_e     = e;
    wait_accept(ok);
    check("accept", {31'd0, ok}, 32'd1);
    in_valid = 1'b0;
    in_g     = ~g;
    in_e     = ~e;
  endtask

  initial begin
    int   lat;
    bit   ok;
    bit   seen;
    logic [17:0] gseq;

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_g      = '0;
    in_e      = '0;
    fork
      forever begin
        @(negedge clk);
        compare();
      end
    join_none

    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mult_rst", {31'd0, mult_rst}, 32'd1);
    check("rst_e_init", {24'd0, e_init}, 32'd0);
    check("rst_out_p", {16'd0, out_p}, 32'd0);
    #2 rst = 1'b1;

    // FF x AA, immediate drain
    out_ready = 1'b1;
    send(8'hFF, 8'hAA);
    gseq = '0;
    lat  = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat <= 18) gseq[lat-1] = g_input;
    end
    check("lat1", lat, 32'd19);
    check("p1", {16'd0, out_p}, 32'h0000A956);
    check("gseq", {14'd0, gseq}, 32'h000000FF);
    @(negedge clk);
    check("pulse1", {31'd0, out_valid}, 32'd0);
    check("rdy1", {31'd0, in_ready}, 32'd1);

    // back-to-back with in_valid held high
    @(negedge clk);
    in_valid = 1'b1;
    in_g     = 8'h80;
    in_e     = 8'h80;
    wait_accept(ok);
    check("acc2a", {31'd0, ok}, 32'd1);
    in_g = 8'h00;
    in_e = 8'hFF;
    wait_valid(lat);
    check("lat2a", lat, 32'd19);
    check("p2a", {16'd0, out_p}, 32'h00004000);
    @(negedge clk);
    check("rdy2", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("acc2b_rdy", {31'd0, in_ready}, 32'd0);
    check("acc2b_e", {24'd0, e_init}, 32'h000000FF);
    in_valid = 1'b0;
    wait_valid(lat);
    check("lat2b", lat, 32'd19);
    check("p2b", {16'd0, out_p}, 32'h00000000);
    @(negedge clk);

    // stalled downstream
    out_ready = 1'b0;
    send(8'h03, 8'h05);
    wait_valid(lat);
    check("p3", {16'd0, out_p}, 32'h0000000F);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_v", {31'd0, out_valid}, 32'd1);
      check("hold_p", {16'd0, out_p}, 32'h0000000F);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("rel3", {31'd0, out_valid}, 32'd0);

    // abort at SHIFT step 6
    send(8'hFF, 8'hAA);
    repeat (7) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("ab_in_ready", {31'd0, in_ready}, 32'd1);
    check("ab_mult_rst", {31'd0, mult_rst}, 32'd1);
    check("ab_g", {31'd0, g_input}, 32'd0);
    check("ab_e", {24'd0, e_init}, 32'd0);
    check("ab_v", {31'd0, out_valid}, 32'd0);
    check("ab_p", {16'd0, out_p}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("ab_noval", {31'd0, seen}, 32'd0);
    send(8'h0F, 8'h11);
    wait_valid(lat);
    check("lat4", lat, 32'd19);
    check("p4", {16'd0, out_p}, 32'h000000FF);
    @(negedge clk);

    // random pairs, random backpressure
    for (int i = 0; i < 200; i++) begin
      int n;
      out_ready = 1'($urandom);
      send(8'($urandom), 8'($urandom));
      n = 0;
      while (busy && n < 200) begin
        @(negedge clk);
        out_ready = 1'($urandom);
        n++;
      end
      check("rand_done", {31'd0, busy}, 32'd0);
    end

`ifdef MULT_SERIAL_SEQ_CHECK_EN
    // forcing o low at step 4 clears product bit 2
    out_ready = 1'b0;
    send(8'hFF, 8'hAA);
    repeat (5) @(negedge clk);
    o_force = 1'b1;
    p_mask  = 16'h0004;
    @(negedge clk);
    o_force = 1'b0;
    wait_valid(lat);
    check("chk_p", {16'd0, out_p}, 32'h0000A952);
    check("chk_err1", {31'd0, chk_err}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("chk_clr", {31'd0, chk_err}, 32'd0);
    @(negedge clk);
    p_mask = '0;
    send(8'hFF, 8'hAA);
    wait_valid(lat);
    check("chk_ok_p", {16'd0, out_p}, 32'h0000A956);
    check("chk_err0", {31'd0, chk_err}, 32'd0);
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
